opti_sos_mc: RTL and testbench
==============================

Name: opti_sos_mc

Overview:
- Parametrised, multi-channel, time-multiplexed Direct Form I biquad (second-order IIR section).
- One shared multiplier-accumulator evaluates y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2 over five cycles.
- Per-channel histories are held in internal register banks.
- Adds valid/ready handshaking on both sides, rounding, saturation, a per-sample bypass, and a history clear.
- Intended as the building block for cascaded multi-channel SOS filter chains.

Parameters:
DATA_W, 24, signed sample width
COEF_W, 24, signed coefficient width
FRAC_W, 22, fractional bits of coefficients (1.0 = 1<<FRAC_W)
NCH, 4, number of channels (1..16)
CH_W, 2, channel index width; must satisfy 2^CH_W >= NCH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample x[n]
in_ch  in  CH_W  channel of in_data
in_bypass  in  1  sample passes unfiltered
b0,b1,b2,a1,a2  in  COEF_W each  signed coefficients, shared by all channels
clr_state  in  1  synchronous pulse: zero all channel histories
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out_data  out  DATA_W  signed y[n]
out_ch  out  CH_W  channel of out_data
out_sat  out  1  out_data was saturated
ch_err  out  1  one-cycle pulse: sample with in_ch >= NCH was dropped

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_ch=0, out_sat=0, ch_err=0.
  - FSM=IDLE, accumulator=0, all x1/x2/y1/y2 histories=0.
  - Reset mid-operation aborts the sample in flight; no output is produced for it.
- FSM states: IDLE, MAC0..MAC4, SAT, OUT. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready, latch in_data, in_ch, in_bypass and all five coefficients. Coefficient changes after accept have no effect on that sample.
  - If in_ch >= NCH: pulse ch_err, drop the sample, stay in IDLE.
  - Otherwise go to MAC0.
- MAC0..MAC4, one product per cycle, in this order: +b0·x, +b1·x1, +b2·x2, −a1·y1, −a2·y2.
  - MAC0 loads the accumulator; later states add to it.
  - Product width is DATA_W+COEF_W; accumulator width is DATA_W+COEF_W+3, so there is no internal overflow.
- SAT:
  - acc_r = (acc + 2^(FRAC_W−1)) arithmetic-shifted right by FRAC_W (round half up).
  - Clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; out_sat=1 if clamped.
  - If bypass: out_data=x, out_sat=0.
  - Register out_data/out_ch/out_sat, set out_valid=1, go to OUT.
  - History update for the channel in the same edge: x2←x1, x1←x, y2←y1, y1←out_data (the saturated value; in bypass, y1←x).
- OUT: hold out_valid and all output fields stable until out_valid&out_ready. At that edge out_valid←0 and FSM→IDLE.
- Latency: accept edge E0, out_valid high after edge E6. Minimum issue interval is 8 cycles with out_ready tied high.
- clr_state:
  - In IDLE or OUT: zero all histories at that edge.
  - In MAC*/SAT: wait until the SAT update completes, then clear at the following edge. The in-flight sample uses the old history; the clear wins over that sample's update.
- Channels are fully independent; only the addressed channel's history changes per sample.

Test Plan:
- Identity. Coeffs b0=0x400000 (1.0), others 0; ch0 x=0x100000 → out_data=0x100000, out_ch=0, out_sat=0, out_valid rises exactly 6 edges after accept.
- One-pole recursion. b0=0x200000 (0.5), a1=0xE00000 (−0.5), others 0; ch1 impulse 0x400000 then 0,0 → outputs 0x200000, 0x100000, 0x080000.
- Channel isolation. Same coeffs as the one-pole test; interleave ch0 impulse 0x400000, ch2 zeros, ch0 zero → ch2 outputs 0; second ch0 output 0x100000.
- Saturation.
  - b0=0x7FFFFF, x=0x7FFFFF → out_data=0x7FFFFF, out_sat=1.
  - x=0x800000 → out_data=0x800000, out_sat=1.
  - Then bypass with x=0x123456 → out_data=0x123456, out_sat=0.
- Backpressure and error.
  - Hold out_ready=0 for 10 cycles → out_valid, out_data and out_ch stable, in_ready=0; after release, one transfer only.
  - in_ch=3 with NCH=3 → ch_err pulse for 1 cycle, no out_valid.
- Reset and clear.
  - Assert rst during MAC2 → all outputs at reset values, no output for that sample.
  - Run the one-pole case, pulse clr_state, impulse again → first output 0x200000 (history cleared).

Source files
------------

// File: rtl/opti_sos_mc.sv
// Multi-channel, time-multiplexed Direct Form I biquad sharing one multiply-accumulator.
// Per sample: five MAC cycles, one round/saturate cycle, then a held valid/ready output stage.
module opti_sos_mc #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned COEF_W = 24,
    parameter int unsigned FRAC_W = 22,
    parameter int unsigned NCH    = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_bypass,
    input  logic [COEF_W-1:0] b0,
    input  logic [COEF_W-1:0] b1,
    input  logic [COEF_W-1:0] b2,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] a2,
    input  logic              clr_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_sat,
    output logic              ch_err
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + 3;

    localparam logic signed [ACC_W-1:0] RND_C   = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [CH_W:0]           NCH_C   = (CH_W+1)'(NCH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_MAC4,
        S_SAT,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      byp_q, byp_d;
    logic signed [COEF_W-1:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      clr_pend_q, clr_pend_d;
    logic signed [DATA_W-1:0]  x1_q [NCH];
    logic signed [DATA_W-1:0]  x1_d [NCH];
    logic signed [DATA_W-1:0]  x2_q [NCH];
    logic signed [DATA_W-1:0]  x2_d [NCH];
    logic signed [DATA_W-1:0]  y1_q [NCH];
    logic signed [DATA_W-1:0]  y1_d [NCH];
    logic signed [DATA_W-1:0]  y2_q [NCH];
    logic signed [DATA_W-1:0]  y2_d [NCH];
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic                      out_sat_q, out_sat_d;
    logic                      ch_err_q, ch_err_d;

    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [DATA_W-1:0]  data_sel;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_rnd;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [DATA_W-1:0]  y_res;
    logic                      y_clip;
    logic                      ch_bad;
    logic                      clr_now;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        ch_d        = ch_q;
        byp_d       = byp_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        acc_d       = acc_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_sat_d   = out_sat_q;
        ch_err_d    = 1'b0;
        coef_sel    = '0;
        data_sel    = '0;

        // Operand select for the shared multiplier, one tap per MAC state.
        case (state_q)
            S_MAC0: begin coef_sel = b0_q; data_sel = x_q;        end
            S_MAC1: begin coef_sel = b1_q; data_sel = x1_q[ch_q]; end
            S_MAC2: begin coef_sel = b2_q; data_sel = x2_q[ch_q]; end
            S_MAC3: begin coef_sel = a1_q; data_sel = y1_q[ch_q]; end
            S_MAC4: begin coef_sel = a2_q; data_sel = y2_q[ch_q]; end
            default: begin coef_sel = '0;  data_sel = '0;         end
        endcase
        prod = PROD_W'(coef_sel) * PROD_W'(data_sel);

        // Round half up, then clamp to the sample range.
        acc_rnd = acc_q + RND_C;
        acc_shr = acc_rnd >>> FRAC_W;
        y_clip  = 1'b0;
        if (acc_shr > SAT_MAX) begin
            y_res  = SAT_MAX[DATA_W-1:0];
            y_clip = 1'b1;
        end else if (acc_shr < SAT_MIN) begin
            y_res  = SAT_MIN[DATA_W-1:0];
            y_clip = 1'b1;
        end else begin
            y_res  = acc_shr[DATA_W-1:0];
        end

        ch_bad = ({1'b0, in_ch} >= NCH_C);

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (ch_bad) begin
                        ch_err_d = 1'b1;
                    end else begin
                        x_d     = in_data;
                        ch_d    = in_ch;
                        byp_d   = in_bypass;
                        b0_d    = b0;
                        b1_d    = b1;
                        b2_d    = b2;
                        a1_d    = a1;
                        a2_d    = a2;
                        state_d = S_MAC0;
                    end
                end
            end
            S_MAC0: begin
                acc_d   = ACC_W'(prod);
                state_d = S_MAC1;
            end
            S_MAC1: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = S_MAC2;
            end
            S_MAC2: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = S_MAC3;
            end
            S_MAC3: begin
                acc_d   = acc_q - ACC_W'(prod);
                state_d = S_MAC4;
            end
            S_MAC4: begin
                acc_d   = acc_q - ACC_W'(prod);
                state_d = S_SAT;
            end
            S_SAT: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                if (byp_q) begin
                    out_data_d = x_q;
                    out_sat_d  = 1'b0;
                    y1_d[ch_q] = x_q;
                end else begin
                    out_data_d = y_res;
                    out_sat_d  = y_clip;
                    y1_d[ch_q] = y_res;
                end
                x2_d[ch_q] = x1_q[ch_q];
                x1_d[ch_q] = x_q;
                y2_d[ch_q] = y1_q[ch_q];
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A clear seen mid-sample is deferred so it lands after that sample's history update.
        clr_now    = (clr_state || clr_pend_q) && (state_q == S_IDLE || state_q == S_OUT);
        clr_pend_d = clr_now ? 1'b0 : (clr_pend_q || clr_state);
        if (clr_now) begin
            x1_d = '{default: '0};
            x2_d = '{default: '0};
            y1_d = '{default: '0};
            y2_d = '{default: '0};
        end

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            ch_q        <= '0;
            byp_q       <= 1'b0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            acc_q       <= '0;
            clr_pend_q  <= 1'b0;
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            byp_q       <= byp_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            acc_q       <= acc_d;
            clr_pend_q  <= clr_pend_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
            ch_err_q    <= ch_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;
    assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_opti_sos_mc.sv
// Directed and randomised bench for opti_sos_mc: integer reference model feeds a scoreboard
// queue at accept time; a negedge monitor pops and compares each output transfer.
module tb_opti_sos_mc;

    localparam int unsigned DW  = 24;
    localparam int unsigned CW  = 24;
    localparam int unsigned FW  = 22;
    localparam int unsigned NC  = 3;
    localparam int unsigned CHW = 2;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [CHW-1:0] ch;
        logic           sat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [CHW-1:0] in_ch;
    logic           in_bypass;
    logic [CW-1:0]  cb0, cb1, cb2, ca1, ca2;
    logic           clr_state;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [CHW-1:0] out_ch;
    logic           out_sat;
    logic           ch_err;

    exp_t   sb[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     acc_cyc  = 0;
    int     rise_cyc = 0;
    logic   ov_prev  = 1'b0;
    longint mx1[NC], mx2[NC], my1[NC], my2[NC];

    opti_sos_mc #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .NCH(NC), .CH_W(CHW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .in_bypass(in_bypass),
        .b0(cb0), .b1(cb1), .b2(cb2), .a1(ca1), .a2(ca2),
        .clr_state(clr_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_sat(out_sat), .ch_err(ch_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NC); i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
    endfunction

    // Reference biquad in 64-bit integer arithmetic using the coefficients present at accept.
    function automatic exp_t model(input logic [DW-1:0] x, input logic [CHW-1:0] ch, input logic byp);
        longint acc, y;
        exp_t   e;
        acc = sx(cb0) * sx(x) + sx(cb1) * mx1[ch] + sx(cb2) * mx2[ch]
            - sx(ca1) * my1[ch] - sx(ca2) * my2[ch];
        y = (acc + (longint'(1) << (FW - 1))) >>> FW;
        e.sat = 1'b0;
        if (y > MAXV) begin
            y = MAXV; e.sat = 1'b1;
        end else if (y < MINV) begin
            y = MINV; e.sat = 1'b1;
        end
        if (byp) begin
            y = sx(x); e.sat = 1'b0;
        end
        mx2[ch] = mx1[ch]; mx1[ch] = sx(x);
        my2[ch] = my1[ch]; my1[ch] = y;
        e.d  = DW'(y);
        e.ch = ch;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && ov_prev !== 1'b1) rise_cyc = cyc;
        ov_prev = out_valid;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("out_ch", out_ch, e.ch);
                check("out_sat", out_sat, e.sat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [CHW-1:0] ch, input logic byp,
                        input bit track);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1; in_data = x; in_ch = ch; in_bypass = byp;
        if (track) sb.push_back(model(x, ch, byp));
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && n < 200) begin tick(); n++; end
        if (n >= 200) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic set_coefs(input logic [CW-1:0] vb0, vb1, vb2, va1, va2);
        cb0 = vb0; cb1 = vb1; cb2 = vb2; ca1 = va1; ca2 = va2;
    endtask

    function automatic logic [CW-1:0] rcoef();
        return CW'($urandom_range(0, 32'h1FFFFF)) - CW'(32'h100000);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; in_bypass = 1'b0;
        clr_state = 1'b0; out_ready = 1'b1;
        set_coefs('0, '0, '0, '0, '0);
        model_clear();
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_ch_err", ch_err, 0);
        rst = 1'b0;
        tick();

        // Identity: b0 = 1.0, ch0 x = 0x100000 -> 0x100000, six edges to out_valid.
        set_coefs(24'h400000, '0, '0, '0, '0);
        send(24'h100000, 2'd0, 1'b0, 1'b1);
        wait_drain();
        check("latency", rise_cyc - acc_cyc, 6);

        // One-pole on ch1: 0x200000, 0x100000, 0x080000; back-to-back issue every 8 cycles.
        set_coefs(24'h200000, '0, '0, 24'hE00000, '0);
        send(24'h400000, 2'd1, 1'b0, 1'b1);
        first_acc = acc_cyc;
        send(24'h000000, 2'd1, 1'b0, 1'b1);
        check("issue_interval", acc_cyc - first_acc, 8);
        send(24'h000000, 2'd1, 1'b0, 1'b1);
        wait_drain();

        // Clear in IDLE, then isolation: ch0 0x200000, ch2 0, ch2 0, ch0 0x100000.
        clr_state = 1'b1; tick(); clr_state = 1'b0; model_clear();
        send(24'h400000, 2'd0, 1'b0, 1'b1);
        send(24'h000000, 2'd2, 1'b0, 1'b1);
        send(24'h000000, 2'd2, 1'b0, 1'b1);
        send(24'h000000, 2'd0, 1'b0, 1'b1);
        wait_drain();

        // Saturation both rails, then bypass passes 0x123456 unsaturated.
        set_coefs(24'h7FFFFF, '0, '0, '0, '0);
        send(24'h7FFFFF, 2'd0, 1'b0, 1'b1);
        send(24'h800000, 2'd0, 1'b0, 1'b1);
        send(24'h123456, 2'd0, 1'b1, 1'b1);
        wait_drain();

        // Random taps on all five coefficients; coefficients change while each sample is in flight.
        for (int i = 0; i < 14; i++) begin
            set_coefs(rcoef(), rcoef(), rcoef(), rcoef(), rcoef());
            send(DW'($urandom), CHW'($urandom_range(0, NC - 1)), ($urandom_range(0, 5) == 0), 1'b1);
        end
        wait_drain();

        // Backpressure: output held stable for 10 cycles, then exactly one transfer.
        set_coefs(24'h300000, '0, '0, '0, '0);
        out_ready = 1'b0;
        send(24'h0ABCDE, 2'd2, 1'b0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) check("bp_valid_timeout", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            if (sb.size() > 0) begin
                check("bp_data", out_data, sb[0].d);
                check("bp_ch", out_ch, sb[0].ch);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_one_xfer", out_valid, 0);
        check("bp_sb_empty", sb.size(), 0);

        // Out-of-range channel: one-cycle ch_err, sample dropped.
        send(24'h111111, 2'd3, 1'b0, 1'b0);
        check("ch_err_pulse", ch_err, 1);
        check("ch_err_in_ready", in_ready, 1);
        tick();
        check("ch_err_clear", ch_err, 0);
        repeat (8) tick();
        check("ch_err_no_out", out_valid, 0);

        // Clear during MAC2: in-flight ch1 uses old history, clear wins afterwards.
        set_coefs(24'h200000, '0, '0, 24'hE00000, '0);
        send(24'h400000, 2'd1, 1'b0, 1'b1);
        tick(); tick();
        clr_state = 1'b1; tick(); clr_state = 1'b0;
        model_clear();
        wait_drain();
        send(24'h000000, 2'd0, 1'b0, 1'b1);
        send(24'h400000, 2'd1, 1'b0, 1'b1);
        wait_drain();

        // Reset during MAC2 aborts the sample and clears histories.
        send(24'h7FFFFF, 2'd2, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_out_ch", out_ch, 0);
        check("mrst_out_sat", out_sat, 0);
        check("mrst_ch_err", ch_err, 0);
        tick();
        rst = 1'b0;
        model_clear();
        repeat (10) tick();
        check("mrst_no_out", out_valid, 0);
        send(24'h400000, 2'd1, 1'b0, 1'b1);
        send(24'h000000, 2'd1, 1'b0, 1'b1);
        wait_drain();

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
